ray_dispatcher: RTL and testbench
=================================

RAY_DISPATCHER -- requirements
Module: ray_dispatcher

Interface
REQ-001 SHALL have parameter H_RES, default 640, pixels per line (>=1).
REQ-002 SHALL have parameter V_RES, default 480, lines per frame (>=1).
REQ-003 SHALL have parameter MAX_INFLIGHT, default 16, maximum rays issued but not yet popped to output (power of 2, >=2).
REQ-004 Ports, one clock; reset is asynchronous and active-high:
- clk  in  1  sole clock
- rst  in  1  asynchronous active-high reset
- start  in  1  begin frame; honoured only in IDLE
- cfg_x_start, cfg_y_start  in  fp  screen coordinate of pixel (0,0)
- cfg_x_step, cfg_y_step  in  fp  per-column and per-line increments
- ray_valid  out  1  issue pulse to ray unit valid_in
- ray_screen_x, ray_screen_y  out  fp  coordinates of the issued ray
- res_valid  in  1  ray unit valid_out
- res_hit  in  1  ray unit hit
- res_point  in  vec3  ray unit surface_point
- out_valid  out  1  pixel result available
- out_ready  in  1  downstream accepts
- out_hit, out_point  out  1, vec3  pixel result
- out_sof, out_eol, out_eof  out  1  first pixel, last of line, last of frame
- busy  out  1  high outside IDLE
- done  out  1  one-cycle pulse when frame complete
- overflow  out  1  sticky: result arrived with FIFO full

Function
REQ-005 SHALL use FSM states IDLE, ISSUE, DRAIN, DONE.
REQ-006 IDLE->ISSUE when start=1; cfg_* SHALL be latched on that edge and col, row, credits cleared.
REQ-007 In ISSUE, ray_valid SHALL be asserted in a cycle iff credits < MAX_INFLIGHT; at most one ray per cycle.
REQ-008 ray_screen_x SHALL equal x_start + col*x_step and ray_screen_y y_start + row*y_step, formed by accumulation (add step per column, reset x at line wrap), wrapping at fp width, no saturation.
REQ-009 col SHALL increment per issue, wrap to 0 at H_RES-1 with row increment; after issuing pixel (H_RES-1, V_RES-1) FSM SHALL go ISSUE->DRAIN.
REQ-010 credits SHALL +1 per issue, -1 per output handshake (out_valid & out_ready); simultaneous events leave it unchanged.
REQ-011 Results SHALL be returned in issue order; each res_valid pushes {res_hit, res_point} into a MAX_INFLIGHT-deep FIFO in the same cycle.
REQ-012 A push with FIFO full SHALL be dropped and set overflow until reset.
REQ-013 out_valid SHALL equal FIFO non-empty; out_hit/out_point SHALL hold stable while out_valid & !out_ready.
REQ-014 Output counters SHALL drive out_sof on pixel 0, out_eol on col H_RES-1, out_eof on the final pixel, aligned with the FIFO head.
REQ-015 DRAIN->DONE on the handshake of the out_eof pixel; DONE SHALL assert done for one cycle then return to IDLE.
REQ-016 Minimum latency from res_valid to out_valid SHALL be 1 cycle; with out_ready=1 and no credit stall throughput SHALL be 1 pixel/cycle.
REQ-017 start while busy SHALL be ignored; H_RES=V_RES=1 SHALL give sof, eol, eof on the same pixel.

Reset
REQ-018 On rst: state IDLE, FIFO empty, credits/col/row/output counters 0; ray_valid, out_valid, busy, done, overflow, out_sof/eol/eof 0; ray_screen_x/y 0.
REQ-019 rst mid-frame SHALL abandon the frame; results arriving after reset release in IDLE SHALL be discarded, not pushed.

Structure
REQ-020 fp, vec3 SHALL come from the existing shared headers; a pixel_result_t {hit, point} typedef SHALL be added to vector_pkg.
REQ-021 The FIFO SHALL be a separate sub-module result_fifo (parameterised depth and payload type).

Verification
REQ-022 H_RES=4,V_RES=2, start, x_start=0,step=1.0, ray unit model latency 10, out_ready=1 -> 8 rays with x 0,1,2,3,0,1,2,3 and y 0,0,0,0,1,1,1,1; 8 outputs in order; eol on 4th and 8th; eof on 8th; done 1 cycle after.
REQ-023 MAX_INFLIGHT=4, out_ready=0 -> exactly 4 ray_valid pulses then stall; raising out_ready resumes issue one per pop.
REQ-024 Random out_ready toggling, latency 3 -> out_point unchanged while stalled; all pixels delivered once, overflow=0.
REQ-025 Force extra res_valid with FIFO full -> overflow=1, sticky until rst.
REQ-026 Assert rst during ISSUE at pixel 3 -> all outputs zero next cycle; late res_valid ignored; new start produces a complete frame.
REQ-027 H_RES=V_RES=1 -> single pixel with sof, eol, eof high together; start during busy ignored.

Source files
------------

// File: rtl/ray_dispatcher_pkg.sv
// ray_dispatcher_pkg: dispatcher FSM states and counter sizing helper
package ray_dispatcher_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  function automatic int cnt_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/vector_pkg.sv
// vector_pkg: shared Q16.16 scalar, 3-vector and per-pixel result types
package vector_pkg;
  localparam int FP_W = 32;
  localparam int FP_FRAC = 16;
  typedef logic signed [FP_W-1:0] fp;
  typedef struct packed {
    fp x;
    fp y;
    fp z;
  } vec3;
  typedef struct packed {
    logic hit;
    vec3  point;
  } pixel_result_t;
endpackage

// File: rtl/result_fifo.sv
// result_fifo: in-order FIFO of parameterised depth/payload; drops pushes when full
module result_fifo #(
  parameter int  DEPTH = 16,
  parameter type T     = logic
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  T     din,
  input  logic pop,
  output T     dout,
  output logic empty,
  output logic full
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  T mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout = mem[rd_ptr[AW-1:0]];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end
  always_ff @(posedge clk)
    if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
endmodule

// File: rtl/ray_dispatcher.sv
// ray_dispatcher: issues one ray per pixel under a credit limit and returns results in raster order
module ray_dispatcher
  import vector_pkg::*, ray_dispatcher_pkg::*;
#(
  parameter int H_RES        = 640,
  parameter int V_RES        = 480,
  parameter int MAX_INFLIGHT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  fp    cfg_x_start,
  input  fp    cfg_y_start,
  input  fp    cfg_x_step,
  input  fp    cfg_y_step,
  output logic ray_valid,
  output fp    ray_screen_x,
  output fp    ray_screen_y,
  input  logic res_valid,
  input  logic res_hit,
  input  vec3  res_point,
  output logic out_valid,
  input  logic out_ready,
  output logic out_hit,
  output vec3  out_point,
  output logic out_sof,
  output logic out_eol,
  output logic out_eof,
  output logic busy,
  output logic done,
  output logic overflow
);
  localparam int CW = cnt_w(H_RES);
  localparam int RW = cnt_w(V_RES);
  localparam int NW = $clog2(MAX_INFLIGHT) + 1;
  localparam logic [CW-1:0] COL_LAST = CW'(H_RES - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(V_RES - 1);
  localparam logic [NW-1:0] CRED_MAX = NW'(MAX_INFLIGHT);
  state_t state, state_n;
  fp x_start, x_step, y_step;
  logic [CW-1:0] col, ocol;
  logic [RW-1:0] row, orow;
  logic [NW-1:0] credits;
  pixel_result_t head;
  logic empty, full, push, pop, col_wrap, ocol_wrap;
  // results are only accepted while a frame is live, so stragglers from an abandoned frame vanish
  assign push = res_valid && (state == ISSUE || state == DRAIN);
  assign ray_valid = state == ISSUE && credits < CRED_MAX;
  assign out_valid = !empty;
  assign pop = out_valid && out_ready;
  assign out_hit = head.hit;
  assign out_point = head.point;
  assign col_wrap = col == COL_LAST;
  assign ocol_wrap = ocol == COL_LAST;
  assign out_sof = out_valid && ocol == '0 && orow == '0;
  assign out_eol = out_valid && ocol_wrap;
  assign out_eof = out_eol && orow == ROW_LAST;
  assign busy = state != IDLE;
  assign done = state == DONE;
  result_fifo #(.DEPTH(MAX_INFLIGHT), .T(pixel_result_t)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (pixel_result_t'{res_hit, res_point}),
    .pop   (pop),
    .dout  (head),
    .empty (empty),
    .full  (full)
  );
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start ? ISSUE : IDLE;
      ISSUE:   state_n = ray_valid && col_wrap && row == ROW_LAST ? DRAIN : ISSUE;
      DRAIN:   state_n = pop && out_eof ? DONE : DRAIN;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      x_start      <= '0;
      x_step       <= '0;
      y_step       <= '0;
      ray_screen_x <= '0;
      ray_screen_y <= '0;
      col          <= '0;
      row          <= '0;
      ocol         <= '0;
      orow         <= '0;
      credits      <= '0;
      overflow     <= 1'b0;
    end else begin
      state <= state_n;
      if (push && full) overflow <= 1'b1;
      if (state == IDLE && start) begin
        x_start      <= cfg_x_start;
        x_step       <= cfg_x_step;
        y_step       <= cfg_y_step;
        ray_screen_x <= cfg_x_start;
        ray_screen_y <= cfg_y_start;
        col          <= '0;
        row          <= '0;
        ocol         <= '0;
        orow         <= '0;
        credits      <= '0;
      end else begin
        if (ray_valid) begin
          col          <= col_wrap ? '0 : col + CW'(1);
          row          <= col_wrap ? row + RW'(1) : row;
          ray_screen_x <= col_wrap ? x_start : ray_screen_x + x_step;
          ray_screen_y <= col_wrap ? ray_screen_y + y_step : ray_screen_y;
        end
        if (pop) begin
          ocol <= ocol_wrap ? '0 : ocol + CW'(1);
          orow <= ocol_wrap ? orow + RW'(1) : orow;
        end
        credits <= credits + NW'(ray_valid) - NW'(pop);
      end
    end
  end
endmodule

// File: tb/tb_ray_dispatcher.sv
// tb_ray_dispatcher: randomized self-checking bench against a raster-order reference model
module tb_ray_dispatcher;
  import vector_pkg::*;
  localparam int H = 4, V = 2, MI = 4, N = H * V;
  localparam fp ONE = fp'(32'h0001_0000);
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic start, res_valid, res_hit, out_ready;
  fp xs, ys, xst, yst;
  vec3 res_point;
  logic ray_valid, out_valid, out_hit, sof, eol, eof, busy, done, ovf;
  fp rx, ry;
  vec3 out_point;
  logic start_b, res_valid_b, res_hit_b, out_ready_b;
  fp xs_b, ys_b, xst_b, yst_b;
  vec3 res_point_b;
  logic ray_valid_b, out_valid_b, out_hit_b, sof_b, eol_b, eof_b, busy_b, done_b, ovf_b;
  fp rx_b, ry_b;
  vec3 out_point_b;
  ray_dispatcher #(.H_RES(H), .V_RES(V), .MAX_INFLIGHT(MI)) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_x_start(xs), .cfg_y_start(ys), .cfg_x_step(xst), .cfg_y_step(yst),
    .ray_valid(ray_valid), .ray_screen_x(rx), .ray_screen_y(ry),
    .res_valid(res_valid), .res_hit(res_hit), .res_point(res_point),
    .out_valid(out_valid), .out_ready(out_ready), .out_hit(out_hit), .out_point(out_point),
    .out_sof(sof), .out_eol(eol), .out_eof(eof), .busy(busy), .done(done), .overflow(ovf)
  );
  ray_dispatcher #(.H_RES(1), .V_RES(1), .MAX_INFLIGHT(2)) dut_b (
    .clk(clk), .rst(rst), .start(start_b),
    .cfg_x_start(xs_b), .cfg_y_start(ys_b), .cfg_x_step(xst_b), .cfg_y_step(yst_b),
    .ray_valid(ray_valid_b), .ray_screen_x(rx_b), .ray_screen_y(ry_b),
    .res_valid(res_valid_b), .res_hit(res_hit_b), .res_point(res_point_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .out_hit(out_hit_b), .out_point(out_point_b),
    .out_sof(sof_b), .out_eol(eol_b), .out_eof(eof_b), .busy(busy_b), .done(done_b), .overflow(ovf_b)
  );
  typedef struct {
    int            due;
    pixel_result_t r;
  } pend_t;
  pend_t pend[$];
  int checks = 0, errors = 0;
  int cyc = 0, issued = 0, popped = 0, delivered = 0, lat = 10, mode = 1;
  bit active = 0, exp_done = 0, exp_ovf = 0, stall = 0, extra = 0;
  vec3 held;
  logic held_hit;
  fp m_xs, m_ys, m_xst, m_yst;
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic fp exp_x(input int i);
    return m_xs + fp'(i % H) * m_xst;
  endfunction
  function automatic fp exp_y(input int i);
    return m_ys + fp'(i / H) * m_yst;
  endfunction
  function automatic pixel_result_t ru(input fp x, input fp y);
    pixel_result_t r;
    r.hit = x[17] ^ y[16];
    r.point.x = x ^ fp'(32'h5a5a_5a5a);
    r.point.y = x + y;
    r.point.z = x - y;
    return r;
  endfunction
  task automatic tick(input bit st);
    bit push_now, extra_now;
    pixel_result_t e;
    @(negedge clk);
    cyc++;
    start = st;
    res_valid = 1'b0;
    extra_now = extra;
    extra = 0;
    if (extra_now) begin
      res_valid = 1'b1;
      res_hit = 1'b1;
      res_point = '0;
    end else if (pend.size() > 0 && pend[0].due <= cyc) begin
      res_valid = 1'b1;
      {res_hit, res_point} = pend[0].r;
      void'(pend.pop_front());
    end
    out_ready = mode == 1 ? 1'b1 : mode == 0 ? 1'b0 : 1'($urandom_range(0, 1));
    push_now = res_valid && active && !extra_now;
    chk("ray_valid", ray_valid, bit'(active && issued < N && issued - popped < MI));
    if (ray_valid && issued < N) begin
      chk("ray_x", rx, exp_x(issued));
      chk("ray_y", ry, exp_y(issued));
      pend.push_back('{cyc + lat, ru(rx, ry)});
      issued++;
    end
    chk("out_valid", out_valid, bit'(delivered > popped));
    if (stall) begin
      chk("held_point", out_point, held);
      chk("held_hit", out_hit, held_hit);
    end
    chk("done", done, exp_done);
    chk("busy", busy, bit'(active || exp_done));
    chk("overflow", ovf, exp_ovf);
    exp_done = 0;
    if (out_valid && out_ready && popped < N) begin
      e = ru(exp_x(popped), exp_y(popped));
      chk("out_hit", out_hit, e.hit);
      chk("out_point", out_point, e.point);
      chk("out_sof", sof, bit'(popped == 0));
      chk("out_eol", eol, bit'(popped % H == H - 1));
      chk("out_eof", eof, bit'(popped == N - 1));
      if (popped == N - 1) begin
        active = 0;
        exp_done = 1;
      end
      popped++;
    end
    stall = out_valid && !out_ready;
    held = out_point;
    held_hit = out_hit;
    if (push_now) delivered++;
    if (extra_now && active) exp_ovf = 1;
    if (st && !busy) begin
      active = 1;
      issued = 0;
      popped = 0;
      delivered = 0;
      m_xs = xs;
      m_ys = ys;
      m_xst = xst;
      m_yst = yst;
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    cyc++;
    rst = 1'b1;
    res_valid = 1'b0;
    start = 1'b0;
    #1;
    chk("rst_ray_valid", ray_valid, 1'b0);
    chk("rst_ray_x", rx, '0);
    chk("rst_ray_y", ry, '0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_overflow", ovf, 1'b0);
    chk("rst_sof", sof, 1'b0);
    chk("rst_eol", eol, 1'b0);
    chk("rst_eof", eof, 1'b0);
    @(negedge clk);
    cyc++;
    rst = 1'b0;
    active = 0;
    exp_done = 0;
    exp_ovf = 0;
    stall = 0;
    issued = 0;
    popped = 0;
    delivered = 0;
  endtask
  task automatic start_frame(input int l, input int md, input bit rnd);
    for (int i = 0; i < 50 && pend.size() > 0; i++) tick(0);
    lat = l;
    mode = md;
    xs = rnd ? fp'($urandom) : '0;
    ys = rnd ? fp'($urandom) : '0;
    xst = rnd ? fp'($urandom) : ONE;
    yst = rnd ? fp'($urandom) : ONE;
    tick(1);
  endtask
  task automatic finish_frame(input int md);
    mode = md;
    for (int i = 0; i < 400 && (active || exp_done); i++) tick(0);
    chk("frame_timeout", 1'(active || exp_done), 1'b0);
    chk("rays_issued", issued, N);
    chk("pixels_out", popped, N);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    start = 0; res_valid = 0; res_hit = 0; res_point = '0; out_ready = 1;
    xs = '0; ys = '0; xst = '0; yst = '0;
    start_b = 0; res_valid_b = 0; res_hit_b = 0; res_point_b = '0; out_ready_b = 0;
    xs_b = fp'(32'h0000_0123); ys_b = fp'(32'hffff_8000); xst_b = ONE; yst_b = ONE;
    do_reset();
    chk("rst_b_busy", busy_b, 1'b0);
    chk("rst_b_out_valid", out_valid_b, 1'b0);
    start_frame(10, 1, 0);
    finish_frame(1);
    tick(0);
    start_frame(10, 0, 1);
    repeat (40) tick(0);
    chk("credit_stall_issued", issued, MI);
    finish_frame(1);
    start_frame(3, 2, 1);
    finish_frame(2);
    start_frame(3, 2, 1);
    finish_frame(2);
    start_frame(5, 1, 1);
    for (int i = 0; i < 50 && issued < 3; i++) tick(0);
    chk("pre_reset_issued", issued, 3);
    do_reset();
    repeat (12) tick(0);
    start_frame(4, 1, 0);
    finish_frame(1);
    start_frame(2, 0, 1);
    repeat (20) tick(0);
    chk("fifo_full_issued", issued, MI);
    extra = 1;
    tick(0);
    repeat (4) tick(0);
    chk("overflow_sticky", ovf, 1'b1);
    do_reset();
    tick(0);
    @(negedge clk);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    chk("b_ray_valid", ray_valid_b, 1'b1);
    chk("b_ray_x", rx_b, xs_b);
    chk("b_ray_y", ry_b, ys_b);
    chk("b_busy", busy_b, 1'b1);
    @(negedge clk);
    chk("b_single_ray", ray_valid_b, 1'b0);
    res_valid_b = 1'b1;
    res_hit_b = 1'b1;
    res_point_b = '{fp'(32'h0001_0002), fp'(32'h0003_0004), fp'(32'h0005_0006)};
    start_b = 1'b1;
    @(negedge clk);
    res_valid_b = 1'b0;
    start_b = 1'b0;
    chk("b_out_valid", out_valid_b, 1'b1);
    chk("b_sof", sof_b, 1'b1);
    chk("b_eol", eol_b, 1'b1);
    chk("b_eof", eof_b, 1'b1);
    chk("b_hit", out_hit_b, 1'b1);
    chk("b_point", out_point_b, {32'h0001_0002, 32'h0003_0004, 32'h0005_0006});
    out_ready_b = 1'b1;
    @(negedge clk);
    chk("b_done", done_b, 1'b1);
    chk("b_out_empty", out_valid_b, 1'b0);
    chk("b_no_restart", ray_valid_b, 1'b0);
    @(negedge clk);
    chk("b_idle", busy_b, 1'b0);
    chk("b_done_pulse", done_b, 1'b0);
    chk("b_ignored_start", ray_valid_b, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
